lsu_mem_stage: RTL and testbench
================================

// Module: lsu_mem_stage
// PURPOSE
//  Memory-access stage. It sits directly after the EXU->LSU pipeline registers and before the WBU pipeline registers.
//  It consumes the held LSU-register outputs and performs loads and stores on a req/gnt/rvalid data bus.
//  It forms the regfile writeback value and hands the instruction downstream with the valid/allow_in handshake.
//  Non-memory instructions pass through in zero added cycles.
// PARAMETERS
//  XLEN       32  data/address width; only 32 is supported (RV32)
//  INST_W     32  instruction width, matches pipeline INSTWide
// PORTS
//  clk           in   1       clock
//  rst           in   1       synchronous, active-low reset (0 = reset)
//  lsu_valid     in   1       LSU register stage holds a valid instruction
//  lsu_ready     out  1       instruction finished this cycle; LSU registers may advance
//  i_MemWr       in   1       store
//  i_MemRd       in   1       load (i_MemWr and i_MemRd are never both 1)
//  i_MemOP       in   3       funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu
//  i_ALUres      in   XLEN    effective address, or writeback value for non-loads
//  i_wdata       in   XLEN    store data (rs2)
//  i_inst/i_pc   in   INST_W/XLEN  forwarded unchanged
//  i_RegSrc,i_RegWr,i_IntrEn,i_R_rs1  in 2/1/1/XLEN  forwarded unchanged
//  mem_req       out  1       bus request
//  mem_we        out  1       1 = write
//  mem_addr      out  XLEN    word-aligned address ({addr[31:2],2'b00})
//  mem_wdata     out  XLEN    lane-replicated store data
//  mem_wstrb     out  4       byte strobes
//  mem_gnt       in   1       request accepted this cycle
//  mem_rvalid    in   1       response (read data or write ack), one per granted request
//  mem_rdata     in   XLEN    read data, valid with mem_rvalid
//  wbu_allow_in  in   1       WBU register stage can accept
//  o_valid       out  1       result valid toward WBU
//  o_wb_data     out  XLEN    load result if i_MemRd, else i_ALUres
//  o_fault       out  1       misaligned access; no bus transaction was made
//  o_inst,o_pc,o_RegSrc,o_RegWr,o_IntrEn,o_R_rs1  out  —  pass-through of inputs
// BEHAVIOUR
//  - FSM states: IDLE, REQ, WAIT, DONE. Reset -> IDLE. Reset values: mem_req=0, o_valid=0, lsu_ready=0, o_fault=0, and the load data register = 0.
//  - Misaligned access: h with addr[0]=1, or w with addr[1:0]!=0.
//  - Non-memory or misaligned instruction in IDLE:
//    - o_valid = lsu_valid and lsu_ready = lsu_valid & wbu_allow_in, both combinational.
//    - o_fault = misaligned. FSM stays in IDLE.
//  - Aligned memory op in IDLE with lsu_valid: go to REQ on the next edge. mem_req is registered and rises one cycle after lsu_valid.
//  - REQ: mem_req=1 and the bus fields are held stable until mem_gnt. On mem_gnt, go to WAIT; mem_req drops on the next cycle.
//    - If mem_gnt and mem_rvalid arrive in the same cycle, go directly to DONE.
//  - WAIT: on mem_rvalid, capture the aligned/extended load data and go to DONE. Stores ignore mem_rdata.
//  - DONE: o_valid=1 and lsu_ready=wbu_allow_in. Leave for IDLE when wbu_allow_in=1; otherwise hold o_valid and o_wb_data.
//    - Minimum latency for a memory op is 3 cycles (IDLE->REQ->WAIT->DONE), given gnt and rvalid each in one cycle.
//  - Store lanes: sb wdata={4{d[7:0]}}, wstrb=4'b0001<<a[1:0]; sh wdata={2{d[15:0]}}, wstrb=4'b0011<<a[1:0]; sw wstrb=4'b1111.
//  - Load extract: byte/half selected by a[1:0]; sign-extend for b/h, zero-extend for bu/hu.
//  - Pass-through outputs are combinational from the inputs. LSU registers hold them because lsu_ready stays 0 until completion.
//  - Only one outstanding transaction at a time. A new instruction is not sampled until DONE->IDLE.
//  - Reset mid-transaction: return to IDLE and drop mem_req in the same cycle. The bus is reset with the core, so no stale response is expected.
//  - mem_rvalid in IDLE or REQ without a prior grant is a protocol error. It is ignored; the bench flags it.
// STRUCTURE
//  - Package lsu_pkg: MemOP encodings (MEMOP_B/H/W/BU/HU), the FSM state enum, and the misalign predicate function.
//  - Sub-module lsu_load_align (combinational): in {rdata, addr[1:0], MemOP}, out extended XLEN value.
//  - The store-lane logic stays inline.
// TESTING
//  1. ALU op (MemRd=MemWr=0, ALUres=0x1234), wbu_allow_in=1 -> same cycle o_valid=1, o_wb_data=0x1234, lsu_ready=1, mem_req never 1.
//  2. lb at addr 0x1003, rdata=0x80FF_FF7F, gnt and rvalid one cycle each -> o_wb_data=0xFFFFFF80 in DONE, 3 cycles after lsu_valid; lbu -> 0x00000080.
//  3. sh at addr 0x2002, wdata=0xABCD -> mem_addr=0x2000, wstrb=4'b1100, mem_wdata=0xABCDABCD, mem_we=1; completes on the write-ack rvalid.
//  4. lw at addr 0x1002 -> no mem_req, o_fault=1, o_valid=1 in the same cycle.
//  5. mem_gnt delayed 4 cycles plus wbu_allow_in=0 for 3 cycles in DONE -> mem_req and bus fields stable throughout; o_wb_data held; lsu_ready only on the allow_in cycle.
//  6. rst=0 asserted while in WAIT -> next cycle state=IDLE, mem_req=0, o_valid=0; a fresh lw after reset completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: MemOP encodings, memory-stage FSM states and the misalignment predicate.
package lsu_pkg;
    localparam logic [2:0] MEMOP_B  = 3'b000;
    localparam logic [2:0] MEMOP_H  = 3'b001;
    localparam logic [2:0] MEMOP_W  = 3'b010;
    localparam logic [2:0] MEMOP_BU = 3'b100;
    localparam logic [2:0] MEMOP_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    // funct3[1:0] gives the access size for both signed and unsigned variants
    function automatic logic misaligned(input logic [2:0] op, input logic [1:0] addr);
        return (op[1:0] == 2'b01 && addr[0]) || (op[1:0] == 2'b10 && addr != 2'b00);
    endfunction
endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: selects the addressed byte/half/word of a read word and extends it.
module lsu_load_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      addr,
    input  logic [2:0]      mem_op,
    output logic [XLEN-1:0] data
);
    logic [XLEN-1:0] lane;

    always_comb begin
        lane = rdata >> {addr, 3'b000};
        data = mem_op == MEMOP_B  ? {{(XLEN-8){lane[7]}}, lane[7:0]} :
               mem_op == MEMOP_H  ? {{(XLEN-16){lane[15]}}, lane[15:0]} :
               mem_op == MEMOP_BU ? {{(XLEN-8){1'b0}}, lane[7:0]} :
               mem_op == MEMOP_HU ? {{(XLEN-16){1'b0}}, lane[15:0]} :
               rdata;
    end
endmodule

// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: memory-access stage driving a req/gnt/rvalid bus, one transaction at a time.
module lsu_mem_stage
    import lsu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int INST_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lsu_valid,
    output logic              lsu_ready,
    input  logic              i_MemWr,
    input  logic              i_MemRd,
    input  logic [2:0]        i_MemOP,
    input  logic [XLEN-1:0]   i_ALUres,
    input  logic [XLEN-1:0]   i_wdata,
    input  logic [INST_W-1:0] i_inst,
    input  logic [XLEN-1:0]   i_pc,
    input  logic [1:0]        i_RegSrc,
    input  logic              i_RegWr,
    input  logic              i_IntrEn,
    input  logic [XLEN-1:0]   i_R_rs1,
    output logic              mem_req,
    output logic              mem_we,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic              wbu_allow_in,
    output logic              o_valid,
    output logic [XLEN-1:0]   o_wb_data,
    output logic              o_fault,
    output logic [INST_W-1:0] o_inst,
    output logic [XLEN-1:0]   o_pc,
    output logic [1:0]        o_RegSrc,
    output logic              o_RegWr,
    output logic              o_IntrEn,
    output logic [XLEN-1:0]   o_R_rs1
);
    state_t          state, state_nxt;
    logic [XLEN-1:0] load_q, load_ext;
    logic            mem_op, fault, capture;

    assign mem_op = i_MemRd | i_MemWr;
    assign fault  = mem_op & misaligned(i_MemOP, i_ALUres[1:0]);

    lsu_load_align #(.XLEN(XLEN)) u_align (
        .rdata  (mem_rdata),
        .addr   (i_ALUres[1:0]),
        .mem_op (i_MemOP),
        .data   (load_ext)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            load_q <= '0;
        end else begin
            state <= state_nxt;
            if (capture && i_MemRd) load_q <= load_ext;
        end
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        o_valid   = 1'b0;
        lsu_ready = 1'b0;
        o_fault   = 1'b0;
        case (state)
            IDLE: begin
                if (mem_op && !fault) begin
                    state_nxt = lsu_valid ? REQ : IDLE;
                end else begin
                    o_valid   = lsu_valid;
                    lsu_ready = lsu_valid & wbu_allow_in;
                    o_fault   = lsu_valid & fault;
                end
            end
            REQ: begin
                // an rvalid without a grant is a protocol error and is ignored
                if (mem_gnt) begin
                    state_nxt = mem_rvalid ? DONE : WAIT;
                    capture   = mem_rvalid;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    state_nxt = DONE;
                    capture   = 1'b1;
                end
            end
            DONE: begin
                o_valid   = 1'b1;
                lsu_ready = wbu_allow_in;
                if (wbu_allow_in) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (!rst) {o_valid, lsu_ready, o_fault} = '0;
    end

    // reset removes the request in the same cycle, not one edge later
    assign mem_req   = rst & (state == REQ);
    assign mem_we    = i_MemWr;
    assign mem_addr  = {i_ALUres[XLEN-1:2], 2'b00};
    assign mem_wdata = i_MemOP[1:0] == 2'b00 ? {4{i_wdata[7:0]}} :
                       i_MemOP[1:0] == 2'b01 ? {2{i_wdata[15:0]}} : i_wdata;
    assign mem_wstrb = !i_MemWr              ? 4'b0000 :
                       i_MemOP[1:0] == 2'b00 ? 4'b0001 << i_ALUres[1:0] :
                       i_MemOP[1:0] == 2'b01 ? 4'b0011 << i_ALUres[1:0] : 4'b1111;

    // a faulting load made no access, so it reports the offending address instead
    assign o_wb_data = (i_MemRd && !fault) ? load_q : i_ALUres;
    assign o_inst    = i_inst;
    assign o_pc      = i_pc;
    assign o_RegSrc  = i_RegSrc;
    assign o_RegWr   = i_RegWr;
    assign o_IntrEn  = i_IntrEn;
    assign o_R_rs1   = i_R_rs1;
endmodule

// File: tb/tb_lsu_mem_stage.sv
// tb_lsu_mem_stage: directed vectors with a scoreboard of expected results and bus requests.
module tb_lsu_mem_stage;
    import lsu_pkg::*;

    logic        clk = 1'b0, rst = 1'b0;
    logic        lsu_valid = 1'b0, lsu_ready;
    logic        i_MemWr = 1'b0, i_MemRd = 1'b0;
    logic [2:0]  i_MemOP = 3'b000;
    logic [31:0] i_ALUres = '0, i_wdata = '0, i_pc = 32'h8000_0000, i_R_rs1 = 32'h55;
    logic [31:0] i_inst = 32'h0000_0013;
    logic [1:0]  i_RegSrc = 2'b01;
    logic        i_RegWr = 1'b1, i_IntrEn = 1'b0;
    logic        mem_req, mem_we, mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;
    logic [3:0]  mem_wstrb;
    logic        wbu_allow_in = 1'b1, o_valid, o_fault;
    logic [31:0] o_wb_data, o_inst, o_pc, o_R_rs1;
    logic [1:0]  o_RegSrc;
    logic        o_RegWr, o_IntrEn;

    lsu_mem_stage dut (
        .clk(clk), .rst(rst), .lsu_valid(lsu_valid), .lsu_ready(lsu_ready),
        .i_MemWr(i_MemWr), .i_MemRd(i_MemRd), .i_MemOP(i_MemOP), .i_ALUres(i_ALUres),
        .i_wdata(i_wdata), .i_inst(i_inst), .i_pc(i_pc), .i_RegSrc(i_RegSrc),
        .i_RegWr(i_RegWr), .i_IntrEn(i_IntrEn), .i_R_rs1(i_R_rs1),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .wbu_allow_in(wbu_allow_in), .o_valid(o_valid), .o_wb_data(o_wb_data), .o_fault(o_fault),
        .o_inst(o_inst), .o_pc(o_pc), .o_RegSrc(o_RegSrc), .o_RegWr(o_RegWr),
        .o_IntrEn(o_IntrEn), .o_R_rs1(o_R_rs1)
    );

    always #5 clk = ~clk;

    typedef struct {logic [31:0] wb; logic fault;} res_t;
    typedef struct {logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb; logic we;} bus_t;
    res_t res_q[$];
    bus_t bus_q[$];

    int          tests = 0, fails = 0;
    int          gnt_delay = 0, wait_cnt = 0, stall_left = 0;
    logic        suppress = 1'b0, granted = 1'b0;
    logic [31:0] rdata_val = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // bus slave: grant after gnt_delay request cycles, respond in the cycle after the grant
    initial forever begin
        @(posedge clk); #2;
        mem_rvalid = 1'b0;
        if (!rst) begin
            mem_gnt  = 1'b0;
            wait_cnt = 0;
        end else if (mem_gnt) begin
            mem_gnt    = 1'b0;
            mem_rvalid = !suppress;
            mem_rdata  = rdata_val;
        end else if (mem_req) begin
            if (wait_cnt == gnt_delay) begin
                mem_gnt  = 1'b1;
                wait_cnt = 0;
            end else wait_cnt++;
        end
    end

    // WBU back-pressure for the first stall_left cycles the result is offered
    initial forever begin
        @(posedge clk); #2;
        if (o_valid && stall_left > 0) begin
            wbu_allow_in = 1'b0;
            stall_left--;
        end else wbu_allow_in = 1'b1;
    end

    // monitor: checks bus requests and results against the scoreboard queues
    initial forever begin
        @(negedge clk);
        if (!rst) granted = 1'b0;
        else begin
            if (mem_req) begin
                if (bus_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_req: mem_req=1 addr %h, required no request", mem_addr);
                end else begin
                    chk("bus_addr", mem_addr, bus_q[0].addr);
                    chk("bus_wdata", mem_wdata, bus_q[0].wdata);
                    chk("bus_wstrb", {28'b0, mem_wstrb}, {28'b0, bus_q[0].wstrb});
                    chk("bus_we", {31'b0, mem_we}, {31'b0, bus_q[0].we});
                    if (mem_gnt) begin
                        void'(bus_q.pop_front());
                        granted = 1'b1;
                    end
                end
            end
            if (mem_rvalid) begin
                chk("rvalid_after_grant", {31'b0, granted}, 32'd1);
                granted = 1'b0;
            end
            if (o_valid) begin
                if (res_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_valid: o_valid=1 wb %h, required no result", o_wb_data);
                end else begin
                    chk("wb_data", o_wb_data, res_q[0].wb);
                    chk("fault", {31'b0, o_fault}, {31'b0, res_q[0].fault});
                    if (wbu_allow_in) begin
                        chk("ready_on_allow", {31'b0, lsu_ready}, 32'd1);
                        void'(res_q.pop_front());
                    end else chk("ready_held_low", {31'b0, lsu_ready}, 32'd0);
                end
            end
        end
    end

    task automatic run_op(input string name, input logic rd, input logic wr, input logic [2:0] op,
                          input logic [31:0] alu, input logic [31:0] wd, input logic [31:0] rdat,
                          input int exp_lat, input logic [31:0] exp_wb, input logic exp_fault,
                          input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                          input logic [3:0] exp_wstrb);
        int cyc = 0;
        res_q.push_back('{exp_wb, exp_fault});
        if ((rd || wr) && !exp_fault) bus_q.push_back('{exp_addr, exp_wdata, exp_wstrb, wr});
        rdata_val = rdat;
        i_MemRd = rd; i_MemWr = wr; i_MemOP = op; i_ALUres = alu; i_wdata = wd;
        lsu_valid = 1'b1;
        while (1) begin
            @(negedge clk);
            if (lsu_ready) break;
            cyc++;
            if (cyc > 50) break;
        end
        chk({name, "_latency"}, cyc, exp_lat);
        @(posedge clk); #1;
        lsu_valid = 1'b0; i_MemRd = 1'b0; i_MemWr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        lsu_valid = 1'b1;
        i_ALUres  = 32'h0000_0100;
        #1;
        chk("rst_o_valid", {31'b0, o_valid}, 32'd0);
        chk("rst_lsu_ready", {31'b0, lsu_ready}, 32'd0);
        chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
        lsu_valid = 1'b0; i_MemRd = 1'b1; i_MemOP = MEMOP_W;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_load_reg", o_wb_data, 32'd0);
        chk("rst_o_fault", {31'b0, o_fault}, 32'd0);
        chk("pass_pc", o_pc, 32'h8000_0000);
        chk("pass_rs1", o_R_rs1, 32'h55);
        i_MemRd = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;

        run_op("alu", 0, 0, MEMOP_B, 32'h1234, 0, 0, 0, 32'h1234, 0, 0, 0, 0);
        run_op("lb", 1, 0, MEMOP_B, 32'h1003, 0, 32'h80FF_FF7F, 3, 32'hFFFF_FF80, 0, 32'h1000, 0, 4'b0000);
        run_op("lbu", 1, 0, MEMOP_BU, 32'h1003, 0, 32'h80FF_FF7F, 3, 32'h0000_0080, 0, 32'h1000, 0, 4'b0000);
        run_op("lhu", 1, 0, MEMOP_HU, 32'h1002, 0, 32'h80FF_FF7F, 3, 32'h0000_80FF, 0, 32'h1000, 0, 4'b0000);
        run_op("lw", 1, 0, MEMOP_W, 32'h1004, 0, 32'hDEAD_BEEF, 3, 32'hDEAD_BEEF, 0, 32'h1004, 0, 4'b0000);
        run_op("sh", 0, 1, MEMOP_H, 32'h2002, 32'h0000_ABCD, 32'hFFFF_FFFF, 3, 32'h2002, 0, 32'h2000, 32'hABCD_ABCD, 4'b1100);
        run_op("sb", 0, 1, MEMOP_B, 32'h2003, 32'h1234_5678, 0, 3, 32'h2003, 0, 32'h2000, 32'h7878_7878, 4'b1000);
        run_op("sw", 0, 1, MEMOP_W, 32'h2004, 32'hCAFE_F00D, 0, 3, 32'h2004, 0, 32'h2004, 32'hCAFE_F00D, 4'b1111);
        run_op("lw_mis", 1, 0, MEMOP_W, 32'h1002, 0, 0, 0, 32'h1002, 1, 0, 0, 0);
        run_op("sh_mis", 0, 1, MEMOP_H, 32'h2001, 32'h1, 0, 0, 32'h2001, 1, 0, 0, 0);

        gnt_delay = 4; stall_left = 3;
        run_op("lh_stall", 1, 0, MEMOP_H, 32'h3002, 0, 32'h8001_1234, 10, 32'hFFFF_8001, 0, 32'h3000, 0, 4'b0000);
        gnt_delay = 0;

        suppress = 1'b1;
        bus_q.push_back('{32'h1000, 32'h0, 4'b0000, 1'b0});
        i_MemRd = 1'b1; i_MemOP = MEMOP_W; i_ALUres = 32'h1000; i_wdata = 0; lsu_valid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("t6_in_wait", {30'b0, dut.state}, {30'b0, WAIT});
        rst = 1'b0; lsu_valid = 1'b0; i_MemRd = 1'b0;
        #1;
        chk("t6_req_drop_same_cycle", {31'b0, mem_req}, 32'd0);
        @(posedge clk); #1;
        chk("t6_state_idle", {30'b0, dut.state}, {30'b0, IDLE});
        chk("t6_mem_req", {31'b0, mem_req}, 32'd0);
        chk("t6_o_valid", {31'b0, o_valid}, 32'd0);
        rst = 1'b1; suppress = 1'b0;
        @(posedge clk); #1;
        run_op("lw_after_rst", 1, 0, MEMOP_W, 32'h1008, 0, 32'h1357_9BDF, 3, 32'h1357_9BDF, 0, 32'h1008, 0, 4'b0000);

        repeat (3) @(posedge clk);
        chk("res_queue_empty", res_q.size(), 0);
        chk("bus_queue_empty", bus_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
